div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//   Multi-cycle RV32M divide/remainder unit beside the single-cycle ALU in execute.
//   Runs restoring division, one subtract-and-compare step per clock (same SUB op
//   as the ALU), under a 3-state FSM. Execute stalls on it via a valid/ready
//   handshake and writes back the result when it arrives.
// PARAMETERS
//   XLEN   32   operand/result width; counter width = $clog2(XLEN)
// PORTS
//   clk          in   1     clock, rising edge
//   rst_n        in   1     reset; one clock, synchronous, active-low
//   start_valid  in   1     request valid
//   start_ready  out  1     unit can accept a request (=1 only in IDLE)
//   op           in   2     00 DIV, 01 DIVU, 10 REM, 11 REMU
//   dividend     in   XLEN  rs1 operand
//   divisor      in   XLEN  rs2 operand
//   res_valid    out  1     result valid (=1 only in DONE)
//   res_ready    in   1     consumer takes result
//   result       out  XLEN  quotient or remainder
//   busy         out  1     state != IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): state=IDLE, result=0, counter/internal regs=0.
//     Resulting outputs: start_ready=1, res_valid=0, busy=0.
//     Reset mid-operation aborts it; no result is produced.
//   States: IDLE -> CALC -> DONE -> IDLE. A fast path goes IDLE -> DONE.
//   Accept: start_valid && start_ready at edge T.
//     Latch op, |dividend|, |divisor| and both sign bits.
//     Magnitudes are used only for signed ops; unsigned ops latch raw values.
//   Fast path, checked at accept, next state DONE (res_valid at T+1):
//     divisor==0: DIV/DIVU -> all ones; REM/REMU -> dividend (unmodified)
//     DIV/REM with dividend=0x8000_0000, divisor=0xFFFF_FFFF:
//       DIV -> 0x8000_0000; REM -> 0
//   CALC: XLEN cycles; counter runs XLEN-1 down to 0.
//     Each cycle: shift {rem,quo} left by 1.
//     If the new rem >= divisor (unsigned, XLEN+1-bit compare): rem -= divisor,
//       quo[0]=1; otherwise quo[0]=0.
//     After the step with counter==0, go to DONE.
//   Sign fix-up, applied on entry to DONE:
//     Signed quotient is negated when the sign bits differ.
//     Signed remainder takes the dividend's sign.
//     REM/REMU select the remainder; DIV/DIVU select the quotient.
//   Latency: accept at edge T gives res_valid high from edge T+XLEN+1.
//   DONE: res_valid=1; result held stable while res_ready=0 (any duration).
//     On res_valid && res_ready: go to IDLE, and start_ready=1 in the next cycle.
//     There is no same-cycle result->accept bypass.
//   start_valid in CALC/DONE is ignored (start_ready=0); the request is not queued.
//   Input operands may change after accept without effect.
//   result keeps its last value in IDLE (not cleared except by reset).
//   All arithmetic is XLEN-bit wrap-around, except the XLEN+1-bit compare.
// TESTING
//   1 DIVU 100/7, res_ready=1 -> result=14, res_valid exactly 33 cycles after accept
//   2 REM 0xFFFF_FFF9(-7)/2 -> 0xFFFF_FFFF(-1); DIV same operands -> 0xFFFF_FFFD(-3)
//   3 DIV 5/0 -> 0xFFFF_FFFF at T+1; REMU 5/0 -> 5 at T+1;
//     overflow 0x8000_0000/-1: DIV -> 0x8000_0000, REM -> 0
//   4 DIVU 0xFFFF_FFFF/1 with res_ready low 5 cycles -> result 0xFFFF_FFFF held,
//     start_ready=0 throughout; new start_valid pulses ignored
//   5 rst_n=0 for one edge mid-CALC (counter=10) -> IDLE, res_valid=0, start_ready=1;
//     next request runs correctly
//   6 back-to-back: DIVU 9/3 then REMU 9/4, start_valid held high
//     -> results 3 then 1; second accept one cycle after first handshake

Source files
------------

// File: rtl/div_if.sv
// Request/result bundle between execute and the multi-cycle divide unit.
// Also carries the unit's FSM state so checkers can observe it directly.
interface div_if #(
  parameter int XLEN = 32
);
  // Valid/ready: a transfer happens on a rising clk edge where both valid and
  // ready are high. Valid must not depend combinationally on ready, and the
  // payload is only meaningful while valid is high.
  logic            start_valid;
  logic            start_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            res_valid;
  logic            res_ready;
  logic [XLEN-1:0] result;
  logic            busy;
  logic [1:0]      dbg_state;

  modport master (
    output start_valid, op, dividend, divisor, res_ready,
    input  start_ready, res_valid, result, busy, dbg_state
  );

  modport slave (
    input  start_valid, op, dividend, divisor, res_ready,
    output start_ready, res_valid, result, busy, dbg_state
  );
endinterface

// File: rtl/div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU unit: restoring division, one quotient bit per clock,
// with single-cycle handling of divide-by-zero and signed overflow.
module div_sequencer #(
  parameter int XLEN = 32
) (
  input logic  clk,
  input logic  rst_n,
  div_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q;
  logic            steps_done_q;
  logic [XLEN-1:0] rem_q, quo_q, dvsr_q, result_q;
  logic            op_rem_q, sign_a_q, sign_b_q;

  logic            accept, signed_op, neg_a, neg_b, div_zero, overflow, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;
  logic [XLEN:0]   rem_ext;
  logic            ge;
  logic [XLEN-1:0] rem_step, quo_step, quo_fix, rem_fix, final_res;

  // Request decode and the fast-path outcomes, evaluated while in IDLE.
  always_comb begin
    accept    = bus.start_valid && (state_q == IDLE);
    signed_op = ~bus.op[0];
    neg_a     = signed_op & bus.dividend[XLEN-1];
    neg_b     = signed_op & bus.divisor[XLEN-1];
    mag_a     = neg_a ? -bus.dividend : bus.dividend;
    mag_b     = neg_b ? -bus.divisor : bus.divisor;
    div_zero  = (bus.divisor == '0);
    overflow  = signed_op && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
    fast      = div_zero || overflow;
    fast_res  = '0;
    if (div_zero) begin
      fast_res = bus.op[1] ? bus.dividend : '1;
    end else if (overflow) begin
      fast_res = bus.op[1] ? '0 : MIN_NEG;
    end
  end

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_ext  = {rem_q, quo_q[XLEN-1]};
    ge       = rem_ext >= {1'b0, dvsr_q};
    rem_step = ge ? (rem_ext[XLEN-1:0] - dvsr_q) : rem_ext[XLEN-1:0];
    quo_step = {quo_q[XLEN-2:0], ge};
    quo_fix  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
    rem_fix  = sign_a_q ? -rem_q : rem_q;
    final_res = op_rem_q ? rem_fix : quo_fix;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start_valid) state_d = fast ? DONE : CALC;
      CALC: if (steps_done_q) state_d = DONE;
      DONE: if (bus.res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // CALC spends XLEN cycles stepping and one more applying the sign fix-up.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      steps_done_q <= 1'b0;
      rem_q        <= '0;
      quo_q        <= '0;
      dvsr_q       <= '0;
      result_q     <= '0;
      op_rem_q     <= 1'b0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (accept) begin
            op_rem_q     <= bus.op[1];
            sign_a_q     <= neg_a;
            sign_b_q     <= neg_b;
            rem_q        <= '0;
            quo_q        <= mag_a;
            dvsr_q       <= mag_b;
            cnt_q        <= CW'(XLEN - 1);
            steps_done_q <= 1'b0;
            if (fast) result_q <= fast_res;
          end
        end
        CALC: begin
          if (!steps_done_q) begin
            rem_q <= rem_step;
            quo_q <= quo_step;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0) steps_done_q <= 1'b1;
          end else begin
            result_q     <= final_res;
            steps_done_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.start_ready = (state_q == IDLE);
  assign bus.res_valid   = (state_q == DONE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.result      = result_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: hand-computed results, latency, hold,
// reset abort and back-to-back handshakes.
module tb_div_sequencer;
  localparam int XLEN = 32;
  localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [XLEN-1:0] exp_q[$];

  always #5 clk = ~clk;

  div_if #(.XLEN(XLEN)) bus ();
  div_sequencer #(.XLEN(XLEN)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request; returns 1ns after the accepting edge with operands scrambled.
  task automatic send(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic [XLEN-1:0] exp);
    int n = 0;
    @(negedge clk);
    while (!bus.start_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", bus.start_ready, 1);
    bus.start_valid = 1'b1;
    bus.op          = op;
    bus.dividend    = a;
    bus.divisor     = b;
    exp_q.push_back(exp);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    bus.dividend    = $urandom;
    bus.divisor     = $urandom;
    bus.op          = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_result(input string tag, input int exp_lat);
    int lat = 0;
    logic [XLEN-1:0] e;
    while (!bus.res_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_valid"}, bus.res_valid, 1);
    if (exp_lat >= 0) check({tag, "_lat"}, lat, exp_lat);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
    check(tag, bus.result, e);
  endtask

  task automatic take();
    @(negedge clk);
    bus.res_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.res_ready = 1'b0;
    check("take_ready", bus.start_ready, 1);
    check("take_valid", bus.res_valid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [XLEN-1:0] junk;
    bus.start_valid = 1'b0;
    bus.res_ready   = 1'b0;
    bus.op          = OP_DIV;
    bus.dividend    = '0;
    bus.divisor     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_start_ready", bus.start_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_result", bus.result, 0);
    check("rst_state", bus.dbg_state, 0);
    rst_n = 1'b1;

    // Basic unsigned divide and its latency.
    send(OP_DIVU, 32'd100, 32'd7, 32'd14);
    wait_result("divu_100_7", 33);
    take();

    // Signed results with negative dividend.
    send(OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    wait_result("rem_m7_2", 33);
    take();
    send(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    wait_result("div_m7_2", 33);
    take();
    send(OP_REM, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'hFFFF_FFFE);
    wait_result("rem_m20_m6", 33);
    take();
    send(OP_DIV, 32'hFFFF_FFEC, 32'hFFFF_FFFA, 32'd3);
    wait_result("div_m20_m6", 33);
    take();

    // Fast paths: divide by zero and signed overflow.
    send(OP_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    wait_result("div_5_0", 0);
    take();
    send(OP_REMU, 32'd5, 32'd0, 32'd5);
    wait_result("remu_5_0", 0);
    take();
    send(OP_REM, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9);
    wait_result("rem_m7_0", 0);
    take();
    send(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    wait_result("div_ovf", 0);
    take();
    send(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    wait_result("rem_ovf", 0);
    take();

    // Result held under back-pressure; new requests ignored.
    send(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
    wait_result("divu_max_1", 33);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.start_valid = 1'b1;
      bus.op          = OP_DIV;
      bus.dividend    = 32'd7;
      bus.divisor     = 32'd0;
      @(posedge clk);
      #1;
      check("hold_result", bus.result, 32'hFFFF_FFFF);
      check("hold_start_ready", bus.start_ready, 0);
      check("hold_res_valid", bus.res_valid, 1);
    end
    bus.start_valid = 1'b0;
    take();
    check("idle_keeps_result", bus.result, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("no_queued_req", bus.busy, 0);

    // Reset mid-calculation aborts; next request runs normally.
    send(OP_DIVU, 32'd1000, 32'd3, 32'd333);
    junk = exp_q.pop_front();
    repeat (21) @(posedge clk);
    #1;
    check("mid_calc_state", bus.dbg_state, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("abort_res_valid", bus.res_valid, 0);
    check("abort_start_ready", bus.start_ready, 1);
    check("abort_busy", bus.busy, 0);
    send(OP_DIVU, 32'd1000, 32'd3, 32'd333);
    wait_result("divu_1000_3", 33);
    take();

    // Back-to-back with start_valid and res_ready held high.
    @(negedge clk);
    bus.res_ready   = 1'b1;
    bus.start_valid = 1'b1;
    bus.op          = OP_DIVU;
    bus.dividend    = 32'd9;
    bus.divisor     = 32'd3;
    exp_q.push_back(32'd3);
    exp_q.push_back(32'd1);
    @(posedge clk);
    #1;
    check("b2b_first_busy", bus.busy, 1);
    bus.op       = OP_REMU;
    bus.dividend = 32'd9;
    bus.divisor  = 32'd4;
    wait_result("b2b_divu_9_3", 33);
    @(posedge clk);
    #1;
    check("b2b_gap_ready", bus.start_ready, 1);
    check("b2b_gap_valid", bus.res_valid, 0);
    @(posedge clk);
    #1;
    check("b2b_second_busy", bus.busy, 1);
    bus.start_valid = 1'b0;
    wait_result("b2b_remu_9_4", 33);
    @(posedge clk);
    #1;
    check("b2b_done_ready", bus.start_ready, 1);
    bus.res_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
